div_stream_adapter: RTL and testbench



---
 rtl/div_stream_adapter_pkg.sv | 24 ++
 rtl/div_stream_adapter_if.sv | 42 ++++
 rtl/div_stream_adapter_op_fifo.sv | 64 ++++++
 rtl/div_stream_adapter.sv | 146 ++++++++++++++
 tb/tb_div_stream_adapter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_stream_adapter_pkg.sv
// Shared types for the divider stream front-end: FSM states, result record, dz quotient.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package div_pkg;

  // Width of the divider datapath; the adapter's SIZE parameter tracks this.
  localparam int DIV_SIZE = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } div_state_e;

  // Quotient reported for a zero divisor.
  localparam logic [DIV_SIZE-1:0] DZ_QUO = '1;

  typedef struct packed {
    logic [DIV_SIZE-1:0] quo;
    logic [DIV_SIZE-1:0] rem;
    logic                dz;
    logic                err;
  } div_res_t;

endpackage

// File: rtl/div_stream_adapter_if.sv
// Bundles the operand stream, result stream, divider handshake and busy flag.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carried here; master = adapter, slave = its environment.
interface div_stream_adapter_if #(
  parameter int SIZE = div_pkg::DIV_SIZE
);
  // operand stream
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_num;
  logic [SIZE-1:0] in_den;
  // result stream
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_quo;
  logic [SIZE-1:0] out_rem;
  logic            out_dz;
  logic            out_err;
  // sequential divider handshake
  logic            div_start;
  logic [SIZE-1:0] div_numerador;
  logic [SIZE-1:0] div_denominador;
  logic [SIZE-1:0] div_cociente;
  logic [SIZE-1:0] div_resto;
  logic            div_done;
  // status
  logic            busy;

  modport master (
    input  in_valid, in_num, in_den, out_ready,
    input  div_cociente, div_resto, div_done,
    output in_ready, out_valid, out_quo, out_rem, out_dz, out_err,
    output div_start, div_numerador, div_denominador, busy
  );

  modport slave (
    output in_valid, in_num, in_den, out_ready,
    output div_cociente, div_resto, div_done,
    input  in_ready, out_valid, out_quo, out_rem, out_dz, out_err,
    input  div_start, div_numerador, div_denominador, busy
  );
endinterface

// File: rtl/div_stream_adapter_op_fifo.sv
// Operand-pair FIFO: DEPTH entries of WIDTH bits, registered storage, no fall-through.
// Latency: entry pushed at edge N is visible on pop_dat (and poppable) from edge N+1.
// Backpressure: full blocks push even when a pop happens the same edge; pop ignored when empty.
// Ports: clk, rst_n | push, push_dat, full | pop, pop_dat, empty
module div_op_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  // DEPTH+1 distinct occupancy values separate full from empty.
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so plain increment wraps the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_stream_adapter.sv
// Front-end for the sequential divider: buffers operand pairs, issues start, returns quo/rem.
// Latency: pair pushed at edge N starts the divider after edge N+1; a zero divisor yields a result after edge N+1.
// Backpressure: in_ready = FIFO not full; a new pair pops only when the result slot is empty or being drained.
// Ports: clk, rst_n | bus (master): in_* stream, out_* stream, div_* handshake, busy
module div_stream_adapter
  import div_pkg::*;
#(
  parameter int SIZE    = DIV_SIZE,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  div_stream_adapter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // operand FIFO
  logic [2*SIZE-1:0] fifo_wdat;
  logic [2*SIZE-1:0] fifo_rdat;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [SIZE-1:0]   pop_num;
  logic [SIZE-1:0]   pop_den;

  // FSM, result slot and divider operand registers
  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  div_res_t          res_q, res_d;
  logic              out_vld_q, out_vld_d;
  logic              start_q, start_d;
  logic [SIZE-1:0]   num_q, num_d;
  logic [SIZE-1:0]   den_q, den_d;
  logic              slot_free;

  assign fifo_wdat          = {bus.in_num, bus.in_den};
  assign {pop_num, pop_den} = fifo_rdat;
  assign bus.in_ready       = !fifo_full;

  div_op_fifo #(
    .WIDTH (2*SIZE),
    .DEPTH (DEPTH)
  ) u_op_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (bus.in_valid),
    .push_dat (fifo_wdat),
    .full     (fifo_full),
    .pop      (fifo_pop),
    .pop_dat  (fifo_rdat),
    .empty    (fifo_empty)
  );

  // The slot can take a new result if it is empty or its current one leaves this edge.
  assign slot_free = !out_vld_q || bus.out_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    out_vld_d = out_vld_q;
    start_d   = 1'b0;
    num_d     = num_q;
    den_d     = den_q;
    fifo_pop  = 1'b0;

    // Drain first; any load below overrides it so valid stays high with new data.
    if (out_vld_q && bus.out_ready) begin
      out_vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // div_done here is stale (e.g. from before a reset) and is ignored.
        if (!fifo_empty && slot_free) begin
          fifo_pop = 1'b1;
          if (pop_den == '0) begin
            // Answered locally; the divider never sees a zero divisor.
            res_d     = '{quo: DZ_QUO, rem: pop_num, dz: 1'b1, err: 1'b0};
            out_vld_d = 1'b1;
          end else begin
            num_d   = pop_num;
            den_d   = pop_den;
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        // Done is checked before the timeout so a result on the last cycle still counts.
        if (bus.div_done) begin
          res_d     = '{quo: bus.div_cociente, rem: bus.div_resto, dz: 1'b0, err: 1'b0};
          out_vld_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_d     = '{quo: '0, rem: '0, dz: 1'b0, err: 1'b1};
          out_vld_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      res_q     <= '0;
      out_vld_q <= 1'b0;
      start_q   <= 1'b0;
      num_q     <= '0;
      den_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      out_vld_q <= out_vld_d;
      start_q   <= start_d;
      num_q     <= num_d;
      den_q     <= den_d;
    end
  end

  assign bus.out_valid       = out_vld_q;
  assign bus.out_quo         = res_q.quo;
  assign bus.out_rem         = res_q.rem;
  assign bus.out_dz          = res_q.dz;
  assign bus.out_err         = res_q.err;
  assign bus.div_start       = start_q;
  assign bus.div_numerador   = num_q;
  assign bus.div_denominador = den_q;
  assign bus.busy            = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_div_stream_adapter.sv
// Bench for div_stream_adapter: vector table, corner-case sequences, randomized scoreboard run.
module tb_div_stream_adapter;
  import div_pkg::*;

  localparam int SIZE    = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  div_stream_adapter_if #(.SIZE(SIZE)) bus ();

  div_stream_adapter #(
    .SIZE    (SIZE),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // divider model controls
  bit          hang = 1'b0;
  bit          lat_rand = 1'b0;
  int          lat_fix = 10;
  int          pend = 0;
  int          start_cnt = 0;
  logic [31:0] pq, pr;

  // scoreboard
  bit          sb_on = 1'b0;
  div_res_t    exp_q[$];
  div_res_t    got_q[$];
  bit          hold_prev = 1'b0;
  div_res_t    held;

  typedef struct {
    logic [31:0] num;
    logic [31:0] den;
    int          lat;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dz;
  } vec_t;
  vec_t vt[7];

  int  s0, k, g;
  bit  seen_vld, seen_start;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic div_res_t ref_result(input logic [31:0] n, input logic [31:0] d);
    div_res_t r;
    r.err = 1'b0;
    if (d == 32'd0) begin
      r.quo = 32'hFFFF_FFFF;
      r.rem = n;
      r.dz  = 1'b1;
    end else begin
      r.quo = n / d;
      r.rem = n % d;
      r.dz  = 1'b0;
    end
    return r;
  endfunction

  task automatic push(input logic [31:0] n, input logic [31:0] d);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_num   = n;
    bus.in_den   = d;
    while (!bus.in_ready && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.in_ready) timeout_fail("push_ready");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cnt);
    cnt = 0;
    while (!bus.out_valid && cnt < budget) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!bus.out_valid) timeout_fail("wait_valid");
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    bus.out_ready = 1'b1;
    while ((bus.busy || bus.out_valid) && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 3000) timeout_fail(name);
  endtask

  task automatic sb_check(input string name);
    check({name, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check(name, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Sequential divider model: done pulse 'lat' cycles after start, or never when hung.
  initial begin
    bus.div_done     = 1'b0;
    bus.div_cociente = '0;
    bus.div_resto    = '0;
    forever begin
      @(posedge clk); #1;
      bus.div_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.div_done     = 1'b1;
          bus.div_cociente = pq;
          bus.div_resto    = pr;
        end
      end
      if (bus.div_start) begin
        start_cnt++;
        if (!hang) begin
          pq   = bus.div_numerador / bus.div_denominador;
          pr   = bus.div_numerador % bus.div_denominador;
          pend = lat_rand ? int'($urandom_range(1, 20)) : lat_fix;
        end
      end
    end
  end

  // Handshake monitor and output-hold check, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sb_on && bus.in_valid && bus.in_ready)
          exp_q.push_back(ref_result(bus.in_num, bus.in_den));
        if (sb_on && bus.out_valid && bus.out_ready)
          got_q.push_back('{quo: bus.out_quo, rem: bus.out_rem, dz: bus.out_dz, err: bus.out_err});
        if (hold_prev && bus.out_valid)
          check("hold_stable", {bus.out_quo, bus.out_rem, bus.out_dz, bus.out_err}, held);
        hold_prev = bus.out_valid && !bus.out_ready;
        held      = '{quo: bus.out_quo, rem: bus.out_rem, dz: bus.out_dz, err: bus.out_err};
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_num    = '0;
    bus.in_den    = '0;
    bus.out_ready = 1'b0;

    // ---- reset state ----
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_div_start", bus.div_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_fields", {bus.out_quo, bus.out_rem, bus.out_dz, bus.out_err}, 0);
    check("rst_div_ops", {bus.div_numerador, bus.div_denominador}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- vector table ----
    vt[0] = '{32'd100,          32'd7,   10, 32'd14,          32'd2, 1'b0};
    vt[1] = '{32'd5,            32'd0,    0, 32'hFFFF_FFFF,   32'd5, 1'b1};
    vt[2] = '{32'd0,            32'd3,    1, 32'd0,           32'd0, 1'b0};
    vt[3] = '{32'hFFFF_FFFF,    32'd1,    5, 32'hFFFF_FFFF,   32'd0, 1'b0};
    vt[4] = '{32'd7,            32'd100,  2, 32'd0,           32'd7, 1'b0};
    vt[5] = '{32'd0,            32'd0,    0, 32'hFFFF_FFFF,   32'd0, 1'b1};
    // done arrives on the last counted cycle: must beat the timeout
    vt[6] = '{32'h8000_0001,    32'h10,  63, 32'h0800_0000,   32'd1, 1'b0};

    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      lat_fix = vt[i].lat;
      s0 = start_cnt;
      push(vt[i].num, vt[i].den);
      @(posedge clk); #1;
      if (vt[i].dz) begin
        check("dz_latency", bus.out_valid, 1);
      end else begin
        check("start_pulse", bus.div_start, 1);
        check("start_operands", {bus.div_numerador, bus.div_denominador}, {vt[i].num, vt[i].den});
        @(posedge clk); #1;
        check("start_one_cycle", bus.div_start, 0);
        wait_valid(200, k);
        check("done_latency", k + 1, vt[i].lat + 1);
      end
      check("vec_quo", bus.out_quo, vt[i].quo);
      check("vec_rem", bus.out_rem, vt[i].rem);
      check("vec_dz_err", {bus.out_dz, bus.out_err}, {vt[i].dz, 1'b0});
      @(posedge clk); #1;
      check("vec_consumed", bus.out_valid, 0);
      check("vec_start_count", start_cnt - s0, vt[i].dz ? 0 : 1);
    end

    // ---- backpressure: one in flight/held, four buffered, sixth refused ----
    sb_on = 1'b1;
    lat_rand = 1'b1;
    bus.out_ready = 1'b0;
    s0 = start_cnt;
    push(32'd1000 + $urandom_range(0, 999), 32'd1 + $urandom_range(0, 50));
    for (int i = 1; i < 5; i++) begin
      push($urandom, (i == 2) ? 32'd0 : 32'($urandom_range(0, 9)));
    end
    bus.in_valid = 1'b1;
    bus.in_num   = 32'd77;
    bus.in_den   = 32'd3;
    repeat (30) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_one_start", start_cnt - s0, 1);
    check("bp_busy", bus.busy, 1);
    drain("bp_drain");
    sb_check("bp_order");
    sb_on = 1'b0;

    // ---- hung divider: timeout error, then next pair issues ----
    lat_rand = 1'b0;
    lat_fix = 4;
    hang = 1'b1;
    bus.out_ready = 1'b1;
    push(32'd9, 32'd3);
    push(32'd20, 32'd6);
    check("hang_start", bus.div_start, 1);
    k = 0;
    while (!bus.out_err && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    hang = 1'b0;
    check("timeout_cycles", k, TIMEOUT);
    check("timeout_fields", {bus.out_valid, bus.out_quo, bus.out_rem, bus.out_dz, bus.out_err},
          {1'b1, 32'd0, 32'd0, 1'b0, 1'b1});
    @(posedge clk); #1;
    check("after_to_start", bus.div_start, 1);
    check("after_to_ops", {bus.div_numerador, bus.div_denominador}, {32'd20, 32'd6});
    check("after_to_consumed", bus.out_valid, 0);
    wait_valid(200, k);
    check("after_to_result", {bus.out_quo, bus.out_rem, bus.out_dz, bus.out_err},
          {32'd3, 32'd2, 1'b0, 1'b0});
    @(posedge clk); #1;

    // ---- reset while waiting; late done must be ignored ----
    lat_fix = 20;
    push(32'd50, 32'd5);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("midwait_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_async", {bus.out_valid, bus.div_start, bus.busy, bus.in_ready}, 4'b0001);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_vld = 1'b0;
    seen_start = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_vld = 1'b1;
      if (bus.div_start) seen_start = 1'b1;
    end
    check("late_done_no_valid", seen_vld, 0);
    check("late_done_no_start", seen_start, 0);
    check("late_done_state", {bus.busy, bus.in_ready, bus.out_quo, bus.out_rem, bus.out_dz, bus.out_err},
          {1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0});

    // ---- accept and dz pop on the same edge ----
    lat_fix = 3;
    bus.out_ready = 1'b0;
    push(32'd40, 32'd8);
    push(32'd9, 32'd0);
    wait_valid(50, k);
    check("held_result", {bus.out_quo, bus.out_rem}, {32'd5, 32'd0});
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("held_still", {bus.out_valid, bus.out_quo}, {1'b1, 32'd5});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("swap_valid", bus.out_valid, 1);
    check("swap_fields", {bus.out_quo, bus.out_rem, bus.out_dz, bus.out_err},
          {32'hFFFF_FFFF, 32'd9, 1'b1, 1'b0});
    check("swap_fifo_empty", bus.busy, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("swap_consumed", bus.out_valid, 0);

    // ---- randomized traffic against the reference queue ----
    sb_on = 1'b1;
    lat_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        g = $urandom_range(0, 9);
        bus.in_valid = 1'b1;
        bus.in_num   = $urandom;
        bus.in_den   = (g == 0) ? 32'd0 : (g < 6) ? 32'($urandom_range(1, 15)) : $urandom;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain("rand_drain");
    sb_check("rand");
    sb_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
